// File: rtl/ssd_reader.sv
// rtl/ssd_reader.sv - recovers hex digits from a multiplexed active-low 7-segment bus
module ssd_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid,
  output logic                  err
);

  typedef enum logic {WAIT, LOCKED} state_t;

  localparam logic [7:0] LAST = 8'(STABLE - 1);

  logic [6:0]          seg_m, s_seg;
  logic [DIGITS-1:0]   an_m, s_an;
  logic [DIGITS+6:0]   prev;
  logic                change;
  logic [7:0]          cnt, cnt_nxt;
  state_t              state, state_nxt;
  logic                capture;
  logic                sel_ok;
  logic [3:0]          nib;
  logic                bad;
  logic [DIGITS-1:0]   seen, errmask;
  logic [4*DIGITS-1:0] slots;

  // Synchronisers idle at all ones so reset looks like a blank, deselected bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '1;
      s_seg <= '1;
      an_m  <= '1;
      s_an  <= '1;
      prev  <= '1;
    end else begin
      seg_m <= seg_n;
      s_seg <= seg_m;
      an_m  <= an_n;
      s_an  <= an_m;
      prev  <= {s_an, s_seg};
    end
  end

  assign change = (prev != {s_an, s_seg});
  assign sel_ok = $onehot(~s_an);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      WAIT: begin
        if (change) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = LOCKED;
          capture   = 1'b1;
        end else if (cnt != 8'hFF) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      LOCKED: begin
        if (change) begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (s_seg)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      7'h7F: nib = 4'h0;
      default: bad = 1'b1;
    endcase
  end

  // Frame is published the cycle after the last slot fills; STABLE>=2 keeps
  // that cycle free of a competing capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      seen    <= '0;
      errmask <= '0;
      slots   <= '0;
    end else begin
      valid <= 1'b0;
      if (&seen) begin
        value   <= slots;
        err     <= |errmask;
        valid   <= 1'b1;
        seen    <= '0;
        errmask <= '0;
      end else if (capture && sel_ok) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (!s_an[i]) begin
            slots[4*i +: 4] <= nib;
            seen[i]         <= 1'b1;
            errmask[i]      <= bad;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_reader.sv
// tb/tb_ssd_reader.sv - scoreboard bench for ssd_reader with DIGITS=4, STABLE=4
module tb_ssd_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic        valid;
  logic        err;

  ssd_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg_n (seg_n),
    .an_n  (an_n),
    .value (value),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic        err;
  } res_t;

  typedef struct {
    logic [27:0] segs;
    logic [15:0] exp_value;
    logic        exp_err;
  } vec_t;

  res_t sbq[$];
  res_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got value %h err %b expected no pulse", value, err);
      end else begin
        mon_e = sbq.pop_front();
        check("valid_value", 32'(value), 32'(mon_e.value));
        check("valid_err", 32'(err), 32'(mon_e.err));
      end
    end
  end

  task automatic show(input int d, input logic [6:0] s, input int n);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [27:0] segs, input int n);
    for (int d = 0; d < 4; d++) show(d, segs[7*d +: 7], n);
  endtask

  task automatic idle(input int n);
    an_n  = '1;
    seg_n = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending frames expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[8];

  initial begin
    int k;
    vecs[0] = '{{7'h19, 7'h30, 7'h24, 7'h79}, 16'h4321, 1'b0};
    vecs[1] = '{{7'h19, 7'h30, 7'h7E, 7'h79}, 16'h4301, 1'b1};
    vecs[2] = '{{7'h19, 7'h30, 7'h24, 7'h79}, 16'h4321, 1'b0};
    vecs[3] = '{{7'h7F, 7'h30, 7'h24, 7'h79}, 16'h0321, 1'b0};
    vecs[4] = '{{7'h46, 7'h03, 7'h08, 7'h40}, 16'hCBA0, 1'b0};
    vecs[5] = '{{7'h10, 7'h0E, 7'h06, 7'h21}, 16'h9FED, 1'b0};
    vecs[6] = '{{7'h78, 7'h02, 7'h12, 7'h24}, 16'h7652, 1'b0};
    vecs[7] = '{{7'h00, 7'h7F, 7'h1C, 7'h79}, 16'h8001, 1'b1};

    rst_n = 1'b0;
    seg_n = '1;
    an_n  = '1;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Latency: last digit held until valid appears.
    show(0, 7'h79, 6);
    show(1, 7'h24, 6);
    show(2, 7'h30, 6);
    sbq.push_back('{16'h4321, 1'b0});
    an_n  = 4'b0111;
    seg_n = 7'h19;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (valid === 1'b1) break;
    end
    check("latency", 32'(k - 1), 32'd7);
    drain("latency");
    idle(4);

    foreach (vecs[i]) begin
      sbq.push_back('{vecs[i].exp_value, vecs[i].exp_err});
      scan(vecs[i].segs, 6);
      drain("table");
      idle(3);
      check("hold_value", 32'(value), 32'(vecs[i].exp_value));
      check("hold_err", 32'(err), 32'(vecs[i].exp_err));
    end

    // Short glitch on digit 2 must not be captured.
    show(0, 7'h79, 6);
    show(1, 7'h24, 6);
    show(2, 7'h30, 2);
    show(2, 7'h12, 6);
    sbq.push_back('{16'h4521, 1'b0});
    show(3, 7'h19, 6);
    drain("glitch");
    idle(4);

    // Two anodes active at once: no capture, frame waits for real digits.
    show(0, 7'h79, 6);
    show(1, 7'h24, 6);
    an_n  = 4'b1100;
    seg_n = 7'h30;
    repeat (10) @(negedge clk);
    show(2, 7'h30, 6);
    sbq.push_back('{16'h4321, 1'b0});
    show(3, 7'h19, 6);
    drain("multi_anode");
    idle(4);

    // Long hold must capture once: digit 3 alone cannot complete the next frame.
    show(0, 7'h79, 6);
    show(1, 7'h24, 6);
    show(2, 7'h30, 6);
    sbq.push_back('{16'h4321, 1'b0});
    show(3, 7'h19, 20);
    drain("long_hold");
    show(0, 7'h40, 6);
    show(1, 7'h40, 6);
    show(2, 7'h40, 6);
    idle(12);
    sbq.push_back('{16'h4000, 1'b0});
    show(3, 7'h19, 6);
    drain("after_long_hold");
    idle(4);

    // Reset mid-frame discards partial slots.
    show(0, 7'h79, 6);
    show(1, 7'h24, 6);
    idle(4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_value", 32'(value), 32'h0);
    check("midreset_err", 32'(err), 32'h0);
    check("midreset_valid", 32'(valid), 32'h0);
    rst_n = 1'b1;
    idle(2);
    show(2, 7'h00, 6);
    show(3, 7'h00, 6);
    idle(12);
    sbq.push_back('{16'h8888, 1'b0});
    scan({7'h00, 7'h00, 7'h00, 7'h00}, 6);
    drain("post_reset");
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssd_reader.md
Name: ssd_reader

Overview:
- Monitors a multiplexed, active-low 7-segment display bus (segments plus digit anodes) and recovers the hex digits shown on it.
- Each digit is accepted only after its pattern has been stable for a set number of cycles. The digits of a full scan are assembled into one word, presented with a one-cycle valid strobe.
- Used as the read-back/checker end of the display path: the inverse of the hex-to-segment encoder, on board-level or test-harness segment lines.

Parameters:
- DIGITS, 4: number of multiplexed digits (anode lines); legal range 1..8.
- STABLE, 8: cycles a synchronised {an_n, seg_n} must stay unchanged before capture; legal range 2..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_n  input  7  segment lines, active-low; bit0=a … bit6=g; may be asynchronous to clk
- an_n  input  DIGITS  digit select, active-low; an_n[i]=0 selects digit i; may be asynchronous
- value  output  4*DIGITS  assembled digits; digit i in bits [4i+3:4i]
- valid  output  1  one-cycle pulse when value/err update
- err  output  1  frame contained an undecodable pattern; held until next valid

Behaviour:
- Reset (async assert, sync release): value=0, valid=0, err=0. Synchroniser flops=all ones (inactive), stability counter=0, FSM=WAIT, seen mask=0, error mask=0, digit slots=0.
- Input sync: two-flop synchroniser on seg_n and an_n; all logic below uses the synchronised copies (s_seg, s_an).
- Change detect: register previous {s_an, s_seg}; any bit difference = change.
- Stability FSM, two states:
  - WAIT: counter increments each unchanged cycle; change clears counter. When counter reaches STABLE-1 on an unchanged cycle, go to LOCKED and issue one capture (only if s_an has exactly one zero bit).
  - LOCKED: no further captures. On change, clear counter and go to WAIT.
  - Counter width is 8 bits; it never wraps.
- Decode, exact match on s_seg (active-low codes):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E.
  - 7F (blank) → nibble 0, no error.
  - Any other code → nibble 0 and error.
- Capture into digit i (the zero bit of s_an): slot[i] ← nibble, seen[i] ← 1, errmask[i] ← decode error. Recapturing a digit before frame completion overwrites its slot and errmask bit.
- Anode cases with no capture (FSM still moves to LOCKED):
  - s_an all ones.
  - More than one zero bit in s_an.
- Frame completion: on the cycle after the capture that makes seen all ones:
  - value ← assembled slots (including that capture), err ← OR of errmask, valid=1 for exactly that cycle.
  - seen and errmask clear in that same cycle.
- Latency: input edge → capture is 2 (sync) + STABLE cycles; capture → valid is 1 cycle.
- value and err hold between valid pulses.
- Reset mid-frame discards partial slots; a full new scan is required before the next valid.

Test Plan (DIGITS=4, STABLE=4):
1. Scan an_n=1110,1101,1011,0111 with seg_n=79,24,30,19, 6 cycles each → one valid pulse, value=16'h4321, err=0, valid 7 cycles after the last digit's first cycle on the pins.
2. Same scan, but digit 2 shows seg_n=30 for 2 cycles, then 12 for 6 cycles → value=16'h4521 (glitch ignored), one valid.
3. Digit 1 shows seg_n=7E → valid with err=1, value=16'h4301. Next clean scan → err=0.
4. Digit 3 shows seg_n=7F → value=16'h0321, err=0.
5. an_n=1100 held 10 cycles mid-scan → no capture, frame completes only after remaining digits are scanned. Holding one digit 20 cycles → exactly one capture.
6. Assert rst_n=0 after two digits captured → outputs 0. After release, full 4-digit scan of 8,8,8,8 (seg_n=00) → value=16'h8888, single valid.
